// File: rtl/adc_stream_gen.sv
// adc_stream_gen: frames free-running ADC samples into a data/gate/trig stream with optional
// boxcar decimation, sync-aligned frame start after arm, and a sticky missed-sample flag.
module adc_stream_gen #(
   parameter int dw = 16,
   parameter int cw = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [dw-1:0] adc_data,
   input  logic                 adc_valid,
   input  logic                 arm,
   input  logic                 sync,
   input  logic                 cont,
   input  logic [1:0]           dsh,
   input  logic [cw-1:0]        frame_len,
   output logic signed [dw-1:0] o_data,
   output logic                 o_gate,
   output logic                 o_trig,
   output logic                 running,
   output logic                 gap_err
);
   typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
   state_t state, state_nx;
   logic [1:0] dsh_l;
   logic [cw-1:0] len_l, ocnt;
   logic [2:0] sub;
   logic signed [dw+2:0] acc, sum, rnd, shifted;
   logic last_sub, last_out, emit;
   always_comb begin
      sum = acc + (dw+3)'(adc_data);
      rnd = (dw+3)'((4'd1 << dsh_l) >> 1);
      shifted = (sum + rnd) >>> dsh_l;
      last_sub = {1'b0, sub} == (4'd1 << dsh_l) - 4'd1;
      last_out = cw'(ocnt + 1'b1) == len_l;
      emit = state == RUN && adc_valid && last_sub;
      state_nx = state;
      case (state)
         IDLE:    state_nx = arm ? ARMED : IDLE;
         ARMED:   state_nx = sync ? RUN : ARMED;
         RUN:     state_nx = (emit && last_out && !cont) ? IDLE : RUN;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dsh_l <= '0;
         len_l <= '0;
         ocnt <= '0;
         sub <= '0;
         acc <= '0;
         o_data <= '0;
         o_gate <= 1'b0;
         o_trig <= 1'b0;
         running <= 1'b0;
         gap_err <= 1'b0;
      end else begin
         state <= state_nx;
         o_gate <= emit;
         o_trig <= emit && ocnt == '0;
         // stays high through the final gate so it drops the cycle after it
         running <= state_nx == RUN || emit;
         if (state == IDLE && arm) begin
            dsh_l <= dsh;
            len_l <= frame_len;
            gap_err <= 1'b0;
         end
         if (state == ARMED && sync) begin
            acc <= '0;
            sub <= '0;
            ocnt <= '0;
         end
         if (state == RUN && !adc_valid) gap_err <= 1'b1;
         if (state == RUN && adc_valid) begin
            if (last_sub) begin
               acc <= '0;
               sub <= '0;
               o_data <= shifted[dw-1:0];
               ocnt <= last_out ? '0 : cw'(ocnt + 1'b1);
            end else begin
               acc <= sum;
               sub <= sub + 3'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_adc_stream_gen.sv
// tb_adc_stream_gen: table-driven and sequence checks of adc_stream_gen against a
// scoreboard of expected gated outputs.
module tb_adc_stream_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [15:0] adc_data = '0;
   logic adc_valid = 1'b0, arm = 1'b0, sync = 1'b0, cont = 1'b0;
   logic [1:0] dsh = '0;
   logic [11:0] frame_len = '0;
   logic signed [15:0] o_data;
   logic o_gate, o_trig, running, gap_err;
   int checks = 0, errors = 0;
   typedef struct {int d; logic t;} exp_t;
   exp_t q[$];
   exp_t e_m;
   typedef struct {logic [1:0] dsh; int s[8]; int exp;} vec_t;
   vec_t vt[6];
   adc_stream_gen #(.dw(16), .cw(12)) dut (
      .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .arm(arm),
      .sync(sync), .cont(cont), .dsh(dsh), .frame_len(frame_len), .o_data(o_data),
      .o_gate(o_gate), .o_trig(o_trig), .running(running), .gap_err(gap_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   task automatic cyc(input logic v, input int d, input logic a = 1'b0, input logic s = 1'b0);
      adc_valid = v;
      adc_data = d[15:0];
      arm = a;
      sync = s;
      @(posedge clk);
      #1;
      arm = 1'b0;
      sync = 1'b0;
   endtask
   task automatic push(input int d, input logic t);
      q.push_back('{d, t});
   endtask
   always @(negedge clk) begin
      if (o_gate) begin
         if (q.size() == 0) chk("unexpected_gate", 1, 0);
         else begin
            e_m = q.pop_front();
            chk("sb_data", int'($signed(o_data)), e_m.d);
            chk("sb_trig", int'(o_trig), int'(e_m.t));
         end
      end else if (o_trig) chk("trig_without_gate", 1, 0);
   end
   initial begin
      vt[0] = '{2'd3, '{1, 1, 1, 1, 1, 1, 1, 2}, 1};
      vt[1] = '{2'd3, '{-1, -1, -1, -1, -1, -1, -1, -1}, -1};
      vt[2] = '{2'd3, '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767}, 32767};
      vt[3] = '{2'd3, '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768}, -32768};
      vt[4] = '{2'd1, '{-3, 0, 0, 0, 0, 0, 0, 0}, -1};
      vt[5] = '{2'd2, '{-2, -1, -1, -1, 0, 0, 0, 0}, -1};
      cyc(0, 0);
      cyc(0, 0);
      chk("rst_data", int'(o_data), 0);
      chk("rst_gate", int'(o_gate), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_gap", int'(gap_err), 0);
      rst = 1'b0;
      // pass-through frame
      dsh = 2'd0;
      frame_len = 12'd4;
      cyc(1, 10, 1'b1);
      cyc(1, 11);
      cyc(1, 12, 1'b0, 1'b1);
      chk("pt_running_rise", int'(running), 1);
      for (int i = 0; i < 4; i++) push(13 + i, i == 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 13 + i);
         chk("pt_gate", int'(o_gate), 1);
      end
      chk("pt_running_last", int'(running), 1);
      cyc(1, 17);
      chk("pt_running_fall", int'(running), 0);
      chk("pt_gate_off", int'(o_gate), 0);
      cyc(1, 18);
      chk("pt_drained", q.size(), 0);
      // decimation table
      for (int r = 0; r < 6; r++) begin
         dsh = vt[r].dsh;
         frame_len = 12'd1;
         cyc(0, 0, 1'b1);
         cyc(0, 0, 1'b0, 1'b1);
         push(vt[r].exp, 1'b1);
         for (int i = 0; i < (1 << vt[r].dsh); i++) cyc(1, vt[r].s[i]);
         chk("dec_gate", int'(o_gate), 1);
         cyc(0, 0);
         chk("dec_running", int'(running), 0);
         chk("dec_drained", q.size(), 0);
      end
      // continuous mode
      dsh = 2'd1;
      frame_len = 12'd3;
      cont = 1'b1;
      cyc(1, 0, 1'b1);
      cyc(1, 0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) push(k, (k % 3) == 0);
      for (int k = 0; k < 5; k++) begin
         cyc(1, k);
         cyc(1, k);
      end
      cont = 1'b0;
      cyc(1, 5);
      cyc(1, 5);
      chk("cont_last_gate", int'(o_gate), 1);
      cyc(1, 6);
      chk("cont_stopped", int'(running), 0);
      for (int i = 0; i < 4; i++) cyc(1, 7);
      chk("cont_drained", q.size(), 0);
      // gap error
      dsh = 2'd0;
      frame_len = 12'd4;
      cyc(1, 0, 1'b1);
      chk("gap_clean", int'(gap_err), 0);
      cyc(1, 0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) push(100 + i, i == 0);
      cyc(1, 100);
      cyc(1, 101);
      cyc(0, 999);
      chk("gap_set", int'(gap_err), 1);
      chk("gap_no_gate", int'(o_gate), 0);
      cyc(1, 102);
      cyc(1, 103);
      chk("gap_last_gate", int'(o_gate), 1);
      cyc(1, 0);
      chk("gap_sticky", int'(gap_err), 1);
      chk("gap_drained", q.size(), 0);
      cyc(1, 0, 1'b1);
      chk("gap_cleared_by_arm", int'(gap_err), 0);
      // arm during RUN must not change latched settings
      cyc(1, 0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) push(200 + i, i == 0);
      cyc(1, 200);
      dsh = 2'd3;
      frame_len = 12'd1;
      cyc(1, 201, 1'b1);
      cyc(1, 202);
      cyc(1, 203);
      cyc(1, 0);
      chk("run_arm_running", int'(running), 0);
      chk("run_arm_drained", q.size(), 0);
      // arm+sync in IDLE arms only
      dsh = 2'd2;
      frame_len = 12'd2;
      cyc(1, 5, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1, 5);
      chk("armsync_running", int'(running), 0);
      chk("armsync_gate", int'(o_gate), 0);
      // reset mid-frame with partial accumulator
      cyc(1, 0, 1'b0, 1'b1);
      cyc(1, 7);
      cyc(1, 7);
      chk("mid_running", int'(running), 1);
      rst = 1'b1;
      cyc(1, 7);
      rst = 1'b0;
      chk("mrst_data", int'(o_data), 0);
      chk("mrst_gate", int'(o_gate), 0);
      chk("mrst_trig", int'(o_trig), 0);
      chk("mrst_running", int'(running), 0);
      chk("mrst_gap", int'(gap_err), 0);
      // sync while IDLE does nothing
      cyc(1, 9, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1, 9);
      chk("idle_sync_running", int'(running), 0);
      dsh = 2'd2;
      frame_len = 12'd1;
      cyc(1, 0, 1'b1);
      cyc(1, 0, 1'b0, 1'b1);
      push(4, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1, 4);
      chk("clean_acc_gate", int'(o_gate), 1);
      for (int i = 0; i < 3; i++) cyc(0, 0);
      chk("final_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
